// File: rtl/tetris_display_avl_master_pkg.sv
// Shared definitions for the display-refresh master: FSM states, the display
// slave's register map and the BCD-to-ASCII mapping.
package tetris_disp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CELL_RD,
        CELL_WR,
        TEXT_WR,
        FINISH
    } state_t;

    // Word addresses in the display slave; must track its register map.
    localparam logic [11:0] P1_BOARD_BASE = 12'd0;
    localparam logic [11:0] P2_BOARD_BASE = 12'd200;
    localparam logic [11:0] P1_SCORE_BASE = 12'd436;
    localparam logic [11:0] P1_LEVEL_BASE = 12'd448;
    localparam logic [11:0] P1_LINES_BASE = 12'd460;
    localparam logic [11:0] P2_SCORE_BASE = 12'd400;
    localparam logic [11:0] P2_LEVEL_BASE = 12'd412;
    localparam logic [11:0] P2_LINES_BASE = 12'd424;
    localparam logic [11:0] PALETTE_BASE  = 12'd472;

    // Non-decimal nibbles show up as '?' so corrupted counters are visible.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [11:0] text_base(input logic player, input logic [1:0] fld);
        logic [11:0] b;
        case (fld)
            2'd0:    b = player ? P2_SCORE_BASE : P1_SCORE_BASE;
            2'd1:    b = player ? P2_LEVEL_BASE : P1_LEVEL_BASE;
            default: b = player ? P2_LINES_BASE : P1_LINES_BASE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tetris_display_avl_master_if.sv
// Write-only Avalon-MM bundle between the refresh master and the display slave.
interface tetris_display_avl_master_if;
    logic [11:0] AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [3:0]  AVL_BYTE_EN;
    logic        AVL_WRITE;
    logic        AVL_WAITREQUEST;

    modport master (
        output AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN, AVL_WRITE,
        input  AVL_WAITREQUEST
    );

    modport slave (
        input  AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN, AVL_WRITE,
        output AVL_WAITREQUEST
    );
endinterface

// File: rtl/tetris_display_avl_master.sv
// Refreshes one player's board and score/level/lines text in the display
// slave: 200 cell writes from board RAM, then 18 ASCII digit writes.
module tetris_display_avl_master
    import tetris_disp_pkg::*;
#(
    parameter int BOARD_CELLS = 200,
    parameter int DIGITS      = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  PLAYER,
    input  logic [4*DIGITS-1:0]   SCORE,
    input  logic [4*DIGITS-1:0]   LEVEL,
    input  logic [4*DIGITS-1:0]   LINES,
    output logic [7:0]            CELL_ADDR,
    input  logic [3:0]            CELL_DATA,
    tetris_display_avl_master_if.master avl,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state, state_nxt;
    logic [7:0]          idx;
    logic [DW-1:0]       dig;
    logic [1:0]          fld;
    logic                player_q;
    logic [4*DIGITS-1:0] score_q, level_q, lines_q;

    logic                last_cell, last_char;
    logic [4*DIGITS-1:0] field_val;
    logic [3:0]          nib;
    logic [11:0]         board_base;

    assign last_cell  = (idx == 8'(BOARD_CELLS - 1));
    assign last_char  = (fld == 2'd2) && (dig == DW'(DIGITS - 1));
    assign field_val  = (fld == 2'd0) ? score_q : (fld == 2'd1) ? level_q : lines_q;
    assign nib        = field_val[(DIGITS - 1 - int'(dig)) * 4 +: 4];
    assign board_base = player_q ? P2_BOARD_BASE : P1_BOARD_BASE;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = CELL_RD;
            CELL_RD: state_nxt = CELL_WR;
            CELL_WR: if (!avl.AVL_WAITREQUEST) state_nxt = last_cell ? TEXT_WR : CELL_RD;
            TEXT_WR: if (!avl.AVL_WAITREQUEST && last_char) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot is taken only in IDLE, so a START during a run cannot disturb it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx      <= '0;
            dig      <= '0;
            fld      <= '0;
            player_q <= 1'b0;
            score_q  <= '0;
            level_q  <= '0;
            lines_q  <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    player_q <= PLAYER;
                    score_q  <= SCORE;
                    level_q  <= LEVEL;
                    lines_q  <= LINES;
                    idx      <= '0;
                    dig      <= '0;
                    fld      <= '0;
                end
                CELL_WR: if (!avl.AVL_WAITREQUEST) idx <= last_cell ? 8'd0 : idx + 8'd1;
                TEXT_WR: if (!avl.AVL_WAITREQUEST) begin
                    if (dig == DW'(DIGITS - 1)) begin
                        dig <= '0;
                        fld <= fld + 2'd1;
                    end else begin
                        dig <= dig + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs: everything is a function of registered state, so a
    // stalled write holds its address/data without extra registers.
    always_comb begin
        CELL_ADDR         = '0;
        avl.AVL_ADDR      = '0;
        avl.AVL_WRITEDATA = '0;
        avl.AVL_BYTE_EN   = 4'h0;
        avl.AVL_WRITE     = 1'b0;
        BUSY              = 1'b0;
        DONE              = 1'b0;
        case (state)
            CELL_RD: begin
                CELL_ADDR = idx;
                BUSY      = 1'b1;
            end
            CELL_WR: begin
                CELL_ADDR         = idx;
                BUSY              = 1'b1;
                avl.AVL_WRITE     = 1'b1;
                avl.AVL_BYTE_EN   = 4'hF;
                avl.AVL_ADDR      = board_base + {4'h0, idx};
                avl.AVL_WRITEDATA = {28'h0, CELL_DATA};
            end
            TEXT_WR: begin
                BUSY              = 1'b1;
                avl.AVL_WRITE     = 1'b1;
                avl.AVL_BYTE_EN   = 4'hF;
                avl.AVL_ADDR      = text_base(player_q, fld) + 12'(dig);
                avl.AVL_WRITEDATA = {24'h0, bcd_ascii(nib)};
            end
            FINISH:  DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tetris_display_avl_master.sv
// Directed bench: logs every accepted Avalon write per refresh and compares
// address, data and cycle against hand-derived expectations.
module tb_tetris_display_avl_master;

    logic        CLK = 1'b0;
    logic        RESET, START, PLAYER;
    logic [23:0] SCORE, LEVEL, LINES;
    logic [7:0]  CELL_ADDR;
    logic [3:0]  CELL_DATA;
    logic        BUSY, DONE;

    tetris_display_avl_master_if avl();

    tetris_display_avl_master #(.BOARD_CELLS(200), .DIGITS(6)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PLAYER(PLAYER),
        .SCORE(SCORE), .LEVEL(LEVEL), .LINES(LINES),
        .CELL_ADDR(CELL_ADDR), .CELL_DATA(CELL_DATA),
        .avl(avl), .BUSY(BUSY), .DONE(DONE)
    );

    always #10 CLK = ~CLK;

    // Board RAM: registered read, content i%16.
    logic [3:0] board [0:255];
    always @(posedge CLK) CELL_DATA <= board[CELL_ADDR];

    int n_chk = 0;
    int n_pass = 0;

    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          done_cnt, done_cyc, n_unstable, bad_be, hit_cnt;
    logic        rst_wr, rst_busy, rst_done;
    logic [11:0] rst_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_refresh(input logic pl, input logic [23:0] sc, input logic [23:0] lv,
                               input logic [23:0] ln, input int stall_addr, input int stall_n,
                               input int start2, input int chg, input int rst_at);
        int          stalled;
        logic [11:0] pa;
        logic [31:0] pd;
        logic        pwait;
        wa.delete(); wd.delete(); wc.delete();
        done_cnt = 0; done_cyc = -1; n_unstable = 0; bad_be = 0; hit_cnt = 0;
        stalled = 0; pwait = 1'b0; pa = '0; pd = '0;
        for (int c = 0; c < 440; c++) begin
            START = (c == 0) || (c == start2);
            RESET = (c == rst_at);
            if (c == 0) begin
                PLAYER = pl; SCORE = sc; LEVEL = lv; LINES = ln;
            end else if (c == start2) begin
                PLAYER = ~pl; SCORE = 24'h111111; LEVEL = 24'h111111; LINES = 24'h111111;
            end else if (c == chg) begin
                SCORE = 24'h222222;
            end
            #1;
            if (avl.AVL_WRITE && int'(avl.AVL_ADDR) == stall_addr && stalled < stall_n) begin
                avl.AVL_WAITREQUEST = 1'b1;
                stalled++;
            end else begin
                avl.AVL_WAITREQUEST = 1'b0;
            end
            #1;
            if (pwait && (!avl.AVL_WRITE || avl.AVL_ADDR != pa || avl.AVL_WRITEDATA != pd))
                n_unstable++;
            if (avl.AVL_BYTE_EN != (avl.AVL_WRITE ? 4'hF : 4'h0)) bad_be++;
            if (avl.AVL_WRITE && int'(avl.AVL_ADDR) == stall_addr) hit_cnt++;
            if (avl.AVL_WRITE && !avl.AVL_WAITREQUEST) begin
                wa.push_back(avl.AVL_ADDR);
                wd.push_back(avl.AVL_WRITEDATA);
                wc.push_back(c);
            end
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                rst_wr = avl.AVL_WRITE; rst_busy = BUSY; rst_done = DONE; rst_addr = avl.AVL_ADDR;
            end
            pa = avl.AVL_ADDR; pd = avl.AVL_WRITEDATA;
            pwait = avl.AVL_WRITE && avl.AVL_WAITREQUEST;
            @(posedge CLK); #1;
        end
        START = 1'b0; RESET = 1'b0;
    endtask

    // Expected run: cells at 2i+2, text at 401+k, DONE at 419, shifted by
    // st_n stall cycles for everything from cell 5 on.
    task automatic check_run(input string name, input logic pl, input string s_sc,
                             input string s_lv, input string s_ln, input int st_n);
        int          n, f, d, cyc;
        logic [11:0] ea;
        logic [7:0]  ch;
        chk({name, " nwr"}, wa.size(), 218);
        n = (wa.size() < 218) ? wa.size() : 218;
        for (int i = 0; i < n && i < 200; i++) begin
            cyc = 2 * i + 2 + ((i >= 5) ? st_n : 0);
            chk($sformatf("%s cell%0d addr", name, i), wa[i], (pl ? 200 : 0) + i);
            chk($sformatf("%s cell%0d data", name, i), wd[i], i % 16);
            chk($sformatf("%s cell%0d cyc", name, i), wc[i], cyc);
        end
        for (int k = 0; k < 18 && 200 + k < n; k++) begin
            f  = k / 6;
            d  = k % 6;
            ea = 12'((pl ? 400 : 436) + 12 * f + d);
            ch = (f == 0) ? s_sc[d] : (f == 1) ? s_lv[d] : s_ln[d];
            chk($sformatf("%s txt%0d addr", name, k), wa[200 + k], ea);
            chk($sformatf("%s txt%0d data", name, k), wd[200 + k], {24'h0, ch});
            chk($sformatf("%s txt%0d cyc", name, k), wc[200 + k], 401 + k + st_n);
        end
        chk({name, " done_cnt"}, done_cnt, 1);
        chk({name, " done_cyc"}, done_cyc, 419 + st_n);
        chk({name, " stall_hold"}, n_unstable, 0);
        chk({name, " byte_en"}, bad_be, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) board[i] = 4'(i % 16);
        RESET = 1'b1; START = 1'b0; PLAYER = 1'b0;
        SCORE = '0; LEVEL = '0; LINES = '0;
        avl.AVL_WAITREQUEST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst write", avl.AVL_WRITE, 0);
        chk("rst addr", avl.AVL_ADDR, 0);
        chk("rst wdata", avl.AVL_WRITEDATA, 0);
        chk("rst be", avl.AVL_BYTE_EN, 0);
        chk("rst cell_addr", CELL_ADDR, 0);
        chk("rst busy", BUSY, 0);
        chk("rst done", DONE, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        run_refresh(1'b0, 24'h987654, 24'h000003, 24'h000120, -1, 0, -1, -1, -1);
        check_run("p1", 1'b0, "987654", "000003", "000120", 0);

        run_refresh(1'b1, 24'h012345, 24'h000007, 24'h000000, -1, 0, -1, -1, -1);
        check_run("p2", 1'b1, "012345", "000007", "000000", 0);

        run_refresh(1'b0, 24'h000000, 24'h000001, 24'h000002, 5, 3, -1, -1, -1);
        check_run("stall", 1'b0, "000000", "000001", "000002", 3);
        chk("stall addr5 cycles", hit_cnt, 4);

        run_refresh(1'b0, 24'h555555, 24'h000010, 24'h000099, -1, 0, 50, 60, -1);
        check_run("restart_ign", 1'b0, "555555", "000010", "000099", 0);

        run_refresh(1'b0, 24'h000000, 24'h000000, 24'h000000, -1, 0, -1, -1, 100);
        chk("midrst write", rst_wr, 0);
        chk("midrst busy", rst_busy, 0);
        chk("midrst done", rst_done, 0);
        chk("midrst addr", rst_addr, 0);
        chk("midrst no_done", done_cnt, 0);

        run_refresh(1'b0, 24'h000042, 24'h000001, 24'h000000, -1, 0, -1, -1, -1);
        check_run("after_rst", 1'b0, "000042", "000001", "000000", 0);

        run_refresh(1'b0, 24'hA12345, 24'h000000, 24'h000000, -1, 0, -1, -1, -1);
        check_run("bad_bcd", 1'b0, "?12345", "000000", "000000", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
